// File: rtl/upa2_seq_if.sv
// upa2_seq_if -- request/response bundle for the a2 coefficient update stage.
//   start  : request, sampled only while the stage is idle
//   busy   : high from accepted start through the done cycle
//   done   : one-cycle pulse when A2T is valid
//   PK0..2 : sign bits of current and delayed partial reconstructed signal
//   SIGPK  : 1 = partial signal is zero (gradient term suppressed)
//   A1, A2 : current predictor coefficients (two's complement Q14)
//   TR     : tone-transition flag (only when UPA2_TR_EN is defined)
//   A2T    : updated, unlimited a2
// master = requester, slave = upa2_seq.
interface upa2_seq_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        PK0;
  logic        PK1;
  logic        PK2;
  logic        SIGPK;
  logic [15:0] A1;
  logic [15:0] A2;
  logic [15:0] A2T;
`ifdef UPA2_TR_EN
  logic        TR;
`endif

  modport master (
    output start, PK0, PK1, PK2, SIGPK, A1, A2,
`ifdef UPA2_TR_EN
    output TR,
`endif
    input  busy, done, A2T
  );

  modport slave (
    input  start, PK0, PK1, PK2, SIGPK, A1, A2,
`ifdef UPA2_TR_EN
    input  TR,
`endif
    output busy, done, A2T
  );
endinterface

// File: rtl/upa2_seq.sv
// upa2_seq -- second-order predictor coefficient update (unlimited A2T).
// All arithmetic is sequenced over one shared 17-bit adder:
//   IDLE -> NEGFA -> GRAD -> NEGA2 -> SUMU -> SUMA -> IDLE
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   scan_in0..4, scan_enable, test_mode : scan hooks, no functional use
//   scan_out0..4        : tied low
//   bus (upa2_seq_if.slave) : start/busy/done handshake, operands, A2T
// Optional feature macro: UPA2_TR_EN -- adds TR; TR=1 forces A2T to zero
// at the normal done time.
module upa2_seq (
  input  logic clk,
  input  logic reset,
  input  logic scan_in0,
  input  logic scan_in1,
  input  logic scan_in2,
  input  logic scan_in3,
  input  logic scan_in4,
  input  logic scan_enable,
  input  logic test_mode,
  output logic scan_out0,
  output logic scan_out1,
  output logic scan_out2,
  output logic scan_out3,
  output logic scan_out4,
  upa2_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NEGFA = 3'd1,
    GRAD  = 3'd2,
    NEGA2 = 3'd3,
    SUMU  = 3'd4,
    SUMA  = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [15:0] a1_q, a1_d;
  logic [15:0] a2_q, a2_d;
  logic        pks1_q, pks1_d;
  logic        pks2_q, pks2_d;
  logic        sigpk_q, sigpk_d;
  // t0 carries FA, then UGA2, then UA2; t1 carries ULA2
  logic [16:0] t0_q, t0_d;
  logic [15:0] t1_q, t1_d;
  logic [15:0] a2t_q, a2t_d;
  logic        done_q, done_d;
`ifdef UPA2_TR_EN
  logic        tr_q, tr_d;
`endif

  logic [16:0] fa1;
  logic [16:0] uga2a;
  logic [15:0] a2_sx;
  logic [16:0] add_a, add_b, add_sum;
  logic        unused_scan;

  assign unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                         scan_enable, test_mode};

  // FA1: 4*A1 inside [-8191, 8191], clamped to +/-8191*4 outside it
  always_comb begin
    fa1 = {a1_q[14:0], 2'b00};
    if (!a1_q[15]) begin
      if (a1_q > 16'd8191) fa1 = 17'h07FFC;
    end else begin
      if (a1_q < 16'hE001) fa1 = 17'h18004;
    end
  end

  assign uga2a = pks2_q ? 17'h1C000 : 17'h04000;
  assign a2_sx = {{7{a2_q[15]}}, a2_q[15:7]};

  // Shared adder operand select; negation is done as ~x + 1
  always_comb begin
    add_a = '0;
    add_b = '0;
    unique case (state_q)
      NEGFA: begin
        add_a = pks1_q ? fa1 : ~fa1;
        add_b = {16'd0, ~pks1_q};
      end
      GRAD: begin
        add_a = uga2a;
        add_b = t0_q;
      end
      NEGA2: begin
        add_a = {1'b0, ~a2_sx};
        add_b = 17'd1;
      end
      SUMU: begin
        add_a = {1'b0, t0_q[15:0]};
        add_b = {1'b0, t1_q};
      end
      SUMA: begin
        add_a = {1'b0, a2_q};
        add_b = {1'b0, t0_q[15:0]};
      end
      default: ;
    endcase
  end

  assign add_sum = add_a + add_b;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = NEGFA;
      NEGFA:   state_d = GRAD;
      GRAD:    state_d = NEGA2;
      NEGA2:   state_d = SUMU;
      SUMU:    state_d = SUMA;
      SUMA:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    a1_d    = a1_q;
    a2_d    = a2_q;
    pks1_d  = pks1_q;
    pks2_d  = pks2_q;
    sigpk_d = sigpk_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    a2t_d   = a2t_q;
    done_d  = 1'b0;
`ifdef UPA2_TR_EN
    tr_d    = tr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a1_d    = bus.A1;
          a2_d    = bus.A2;
          pks1_d  = bus.PK0 ^ bus.PK1;
          pks2_d  = bus.PK0 ^ bus.PK2;
          sigpk_d = bus.SIGPK;
`ifdef UPA2_TR_EN
          tr_d    = bus.TR;
`endif
        end
      end
      NEGFA: t0_d = add_sum;
      // UGA2 = sext(UGA2B >> 5), or zero when the partial signal is zero
      GRAD:  t0_d = sigpk_q ? '0 : {1'b0, {4{add_sum[16]}}, add_sum[16:5]};
      NEGA2: t1_d = add_sum[15:0];
      SUMU:  t0_d = {1'b0, add_sum[15:0]};
      SUMA: begin
`ifdef UPA2_TR_EN
        a2t_d = tr_q ? '0 : add_sum[15:0];
`else
        a2t_d = add_sum[15:0];
`endif
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a1_q    <= '0;
      a2_q    <= '0;
      pks1_q  <= 1'b0;
      pks2_q  <= 1'b0;
      sigpk_q <= 1'b0;
      t0_q    <= '0;
      t1_q    <= '0;
      a2t_q   <= '0;
      done_q  <= 1'b0;
`ifdef UPA2_TR_EN
      tr_q    <= 1'b0;
`endif
    end else begin
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      pks1_q  <= pks1_d;
      pks2_q  <= pks2_d;
      sigpk_q <= sigpk_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      a2t_q   <= a2t_d;
      done_q  <= done_d;
`ifdef UPA2_TR_EN
      tr_q    <= tr_d;
`endif
    end
  end

  // Outputs; the done cycle is spent back in IDLE, so busy also covers done_q
  always_comb begin
    bus.busy  = (state_q != IDLE) || done_q;
    bus.done  = done_q;
    bus.A2T   = a2t_q;
    scan_out0 = 1'b0;
    scan_out1 = 1'b0;
    scan_out2 = 1'b0;
    scan_out3 = 1'b0;
    scan_out4 = 1'b0;
  end

endmodule

// File: tb/tb_upa2_seq.sv
// tb_upa2_seq -- self-checking bench for upa2_seq with a signed-integer
// reference model of the a2 update.
module tb_upa2_seq;

  logic clk;
  logic reset;
  logic scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
  logic scan_enable, test_mode;
  logic scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

  int checks = 0;
  int errors = 0;

  upa2_seq_if u_if ();

  upa2_seq dut (
    .clk         (clk),
    .reset       (reset),
    .scan_in0    (scan_in0),
    .scan_in1    (scan_in1),
    .scan_in2    (scan_in2),
    .scan_in3    (scan_in3),
    .scan_in4    (scan_in4),
    .scan_enable (scan_enable),
    .test_mode   (test_mode),
    .scan_out0   (scan_out0),
    .scan_out1   (scan_out1),
    .scan_out2   (scan_out2),
    .scan_out3   (scan_out3),
    .scan_out4   (scan_out4),
    .bus         (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: signed integer arithmetic straight from the update rules
  function automatic logic [15:0] ref_a2t(input logic [15:0] a1, input logic [15:0] a2,
                                          input logic p0, input logic p1, input logic p2,
                                          input logic sg, input logic tr);
    int a1u, a1s, a2u, a2s, fa1, fa, b, hi, uga2, res;
    a1u = int'(a1);
    a1s = (a1u >= 32768) ? a1u - 65536 : a1u;
    if (a1s >= 0) fa1 = (a1s <= 8191) ? a1s * 4 : 32764;
    else          fa1 = (a1u >= 57345) ? (a1u * 4) % 131072 : 98308;
    fa = ((p0 ^ p1) != 1'b0) ? fa1 : (131072 - fa1) % 131072;
    b  = ((((p0 ^ p2) != 1'b0) ? 114688 : 16384) + fa) % 131072;
    hi = b / 32;
    uga2 = sg ? 0 : ((hi >= 2048) ? hi - 4096 : hi);
    a2u = int'(a2);
    a2s = (a2u >= 32768) ? a2u - 65536 : a2u;
    res = a2s + uga2 - (a2s >>> 7);
    res = ((res % 65536) + 65536) % 65536;
    if (tr) res = 0;
    return res[15:0];
  endfunction

  task automatic drive_in(input logic [15:0] a1, input logic [15:0] a2, input logic p0,
                          input logic p1, input logic p2, input logic sg, input logic tr);
    u_if.A1 = a1;
    u_if.A2 = a2;
    u_if.PK0 = p0;
    u_if.PK1 = p1;
    u_if.PK2 = p2;
    u_if.SIGPK = sg;
`ifdef UPA2_TR_EN
    u_if.TR = tr;
`else
    if (tr) u_if.PK0 = p0;
`endif
  endtask

  task automatic drive_junk();
    drive_in($urandom, $urandom, $urandom_range(1), $urandom_range(1), $urandom_range(1),
             $urandom_range(1), $urandom_range(1));
  endtask

  // Issues one request, scrambles inputs, then watches 12 samples taken 1ns
  // after each edge; lat counts edges after the accept edge until done.
  task automatic run_op(input logic [15:0] a1, input logic [15:0] a2, input logic p0,
                        input logic p1, input logic p2, input logic sg, input logic tr,
                        output logic [15:0] res, output int lat, output int bcyc,
                        output int ndone);
    @(negedge clk);
    drive_in(a1, a2, p0, p1, p2, sg, tr);
    u_if.start = 1'b1;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    drive_junk();
    res = 'x; lat = -1; bcyc = 0; ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (u_if.busy === 1'b1) bcyc++;
      if (u_if.done === 1'b1) begin
        ndone++;
        if (lat < 0) begin
          lat = c;
          res = u_if.A2T;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    u_if.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (u_if.A2T !== 16'h0000) begin
      errors++; $display("FAIL reset_a2t got %h exp 0000", u_if.A2T);
    end
    checks++;
    if (u_if.done !== 1'b0 || u_if.busy !== 1'b0) begin
      errors++; $display("FAIL reset_hs got done=%b busy=%b exp 0 0", u_if.done, u_if.busy);
    end
    checks++;
    if ({scan_out0, scan_out1, scan_out2, scan_out3, scan_out4} !== 5'b0) begin
      errors++; $display("FAIL reset_scan got %b exp 00000",
                         {scan_out0, scan_out1, scan_out2, scan_out3, scan_out4});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] va1 [6] = '{16'h0000, 16'h0000, 16'h1000, 16'h7FFF, 16'h8000, 16'hE001};
    logic [15:0] va2 [6] = '{16'h0000, 16'h1000, 16'hF000, 16'h0000, 16'h0000, 16'h4321};
    logic [3:0]  vpk [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b1010};
    logic [15:0] vex [4] = '{16'h0200, 16'h0FE0, 16'hEC20, 16'h05FF};
    logic [15:0] res, exp_v;
    int lat, bcyc, nd;
    for (int i = 0; i < 6; i++) begin
      run_op(va1[i], va2[i], vpk[i][3], vpk[i][2], vpk[i][1], vpk[i][0], 1'b0,
             res, lat, bcyc, nd);
      exp_v = (i < 4) ? vex[i] : ref_a2t(va1[i], va2[i], vpk[i][3], vpk[i][2], vpk[i][1],
                                         vpk[i][0], 1'b0);
      checks++;
      if (res !== exp_v) begin
        errors++; $display("FAIL directed_%0d a2t got %h exp %h", i, res, exp_v);
      end
      checks++;
      if (lat != 5 || nd != 1) begin
        errors++; $display("FAIL directed_%0d timing got lat=%0d ndone=%0d exp 5 1", i, lat, nd);
      end
      checks++;
      if (bcyc != 6) begin
        errors++; $display("FAIL directed_%0d busy_cycles got %0d exp 6", i, bcyc);
      end
      checks++;
      if (u_if.A2T !== exp_v) begin
        errors++; $display("FAIL directed_%0d hold got %h exp %h", i, u_if.A2T, exp_v);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] edges [7] = '{16'd8191, 16'd8192, 16'hE001, 16'hE000, 16'h7FFF, 16'h8000, 16'hFFFF};
    logic [15:0] a1, a2, res, exp_v;
    logic p0, p1, p2, sg, tr;
    int lat, bcyc, nd;
    for (int i = 0; i < 40; i++) begin
      a1 = ($urandom_range(3) == 0) ? edges[$urandom_range(6)] : 16'($urandom);
      a2 = 16'($urandom);
      p0 = 1'($urandom); p1 = 1'($urandom); p2 = 1'($urandom);
      sg = ($urandom_range(3) == 0);
`ifdef UPA2_TR_EN
      tr = ($urandom_range(3) == 0);
`else
      tr = 1'b0;
`endif
      exp_v = ref_a2t(a1, a2, p0, p1, p2, sg, tr);
      run_op(a1, a2, p0, p1, p2, sg, tr, res, lat, bcyc, nd);
      checks++;
      if (res !== exp_v || lat != 5 || nd != 1) begin
        errors++;
        $display("FAIL random_%0d a1=%h a2=%h pk=%b%b%b sg=%b got %h lat=%0d nd=%0d exp %h lat=5 nd=1",
                 i, a1, a2, p0, p1, p2, sg, res, lat, nd, exp_v);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [15:0] exp_v, got;
    int nd, first;
    exp_v = ref_a2t(16'h1000, 16'hF000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive_in(16'h1000, 16'hF000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    u_if.start = 1'b1;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    nd = 0; first = -1; got = 'x;
    for (int c = 0; c < 14; c++) begin
      // extra starts with different operands while busy (c=1,3 and on SUMA)
      if (c == 1 || c == 3 || c == 4) begin
        drive_in(16'h7FFF, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        u_if.start = 1'b1;
      end else begin
        u_if.start = 1'b0;
      end
      @(posedge clk); #1;
      if (u_if.done === 1'b1) begin
        nd++;
        if (first < 0) begin first = c; got = u_if.A2T; end
      end
    end
    checks++;
    if (nd != 1 || first != 4) begin
      errors++; $display("FAIL ignore_start got ndone=%0d at=%0d exp 1 at 4", nd, first);
    end
    checks++;
    if (got !== exp_v) begin
      errors++; $display("FAIL ignore_start_a2t got %h exp %h", got, exp_v);
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] res, exp_v;
    int lat, bcyc, nd;
    // leave a non-zero A2T so the clear is observable
    run_op(16'h0000, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, res, lat, bcyc, nd);
    @(negedge clk);
    drive_in(16'h1000, 16'hF000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    u_if.start = 1'b1;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (u_if.A2T !== 16'h0000 || u_if.busy !== 1'b0 || u_if.done !== 1'b0) begin
      errors++; $display("FAIL abort_state got a2t=%h busy=%b done=%b exp 0000 0 0",
                         u_if.A2T, u_if.busy, u_if.done);
    end
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (u_if.done === 1'b1 || u_if.busy === 1'b1) nd++;
    end
    checks++;
    if (nd != 0 || u_if.A2T !== 16'h0000) begin
      errors++; $display("FAIL abort_no_done got activity=%0d a2t=%h exp 0 0000", nd, u_if.A2T);
    end
    exp_v = ref_a2t(16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, res, lat, bcyc, nd);
    checks++;
    if (res !== exp_v || lat != 5 || nd != 1) begin
      errors++; $display("FAIL abort_recover got %h lat=%0d nd=%0d exp %h 5 1", res, lat, nd, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp1, exp2;
    logic [15:0] got [$];
    int at [$];
    exp1 = ref_a2t(16'h0123, 16'h0456, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp2 = ref_a2t(16'hF00F, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive_in(16'h0123, 16'h0456, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    u_if.start = 1'b1;
    @(posedge clk); #1;
    drive_in(16'hF00F, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // start held through the first operation; next accept is edge N+6
    for (int c = 0; c < 14; c++) begin
      if (c == 6) u_if.start = 1'b0;
      @(posedge clk); #1;
      if (u_if.done === 1'b1) begin
        got.push_back(u_if.A2T);
        at.push_back(c);
      end
    end
    checks++;
    if (got.size() != 2) begin
      errors++; $display("FAIL b2b_count got %0d exp 2", got.size());
    end else begin
      checks++;
      if (got[0] !== exp1 || got[1] !== exp2 || at[0] != 4 || at[1] != 10) begin
        errors++; $display("FAIL b2b_data got %h@%0d %h@%0d exp %h@4 %h@10",
                           got[0], at[0], got[1], at[1], exp1, exp2);
      end
    end
  endtask

`ifdef UPA2_TR_EN
  task automatic test_tr();
    logic [15:0] res;
    int lat, bcyc, nd;
    run_op(16'h0000, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, res, lat, bcyc, nd);
    run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, res, lat, bcyc, nd);
    checks++;
    if (res !== 16'h0000 || lat != 5 || nd != 1 || bcyc != 6) begin
      errors++; $display("FAIL tr_force got %h lat=%0d nd=%0d busy=%0d exp 0000 5 1 6",
                         res, lat, nd, bcyc);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    scan_in0 = 1'b0; scan_in1 = 1'b0; scan_in2 = 1'b0; scan_in3 = 1'b0; scan_in4 = 1'b0;
    scan_enable = 1'b0; test_mode = 1'b0;
    u_if.start = 1'b0;
    drive_in('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
`ifdef UPA2_TR_EN
    test_tr();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
